imem_dmem_arbiter: RTL and testbench

Arbitrates one single-port synchronous BRAM between the RV32I fetch stage (read-only) and the load/store unit (read/write, byte-enabled). It issues the grant in the request cycle and routes 1-cycle-latency read data back to the requester that issued the read. It drives the fetch stall and enforces a bounded fetch wait so data traffic cannot starve instruction fetch. It sits between the IF and MEM stages and the shared memory macro.

---
 rtl/rv32i_pkg.sv | 12 +
 rtl/arb_wait_counter.sv | 39 +++
 rtl/imem_dmem_arbiter.sv | 89 ++++++++
 tb/tb_imem_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: response-owner encoding and the canonical NOP.
package rv32i_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_LS   = 2'd2
  } rsp_owner_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive denied fetch cycles; prio_o hands fetch the
// next grant once the count reaches MAX_WAIT.
module arb_wait_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic if_gnt_i,
  input  logic if_flush_i,
  output logic prio_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_i || if_gnt_i) begin
      cnt_d = '0;
    end else if (!if_flush_i && (cnt_q != CNT_MAX)) begin
      // a flushed cycle is not counted as a denial
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign prio_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port BRAM between instruction fetch and the load/store unit.
// rsp_q: NONE = no read in flight | IF = fetch read in flight | LS = load in flight
module imem_dmem_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_stall_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [3:0]        ls_be_i,
  input  logic [31:0]       ls_addr_i,
  input  logic [31:0]       ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [31:0]       ls_rdata_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  rsp_owner_e rsp_q, rsp_d;
  logic       if_prio;
  logic       if_gnt, ls_gnt;
  logic       unused_addr_bits;

  arb_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_gnt_i   (if_gnt),
    .if_flush_i (if_flush_i),
    .prio_o     (if_prio)
  );

  always_comb begin
    if_gnt      = if_req_i & ~if_flush_i & (~ls_req_i | if_prio);
    ls_gnt      = ls_req_i & ~if_gnt;
    mem_en_o    = if_gnt | ls_gnt;
    mem_we_o    = '0;
    mem_addr_o  = ls_addr_i[ADDR_W-1:2];
    mem_wdata_o = ls_wdata_i;
    rsp_d       = RSP_NONE;
    if (if_gnt) begin
      mem_addr_o = if_addr_i[ADDR_W-1:2];
      rsp_d      = RSP_IF;
    end else if (ls_gnt) begin
      if (ls_we_i) begin
        mem_we_o = ls_be_i;
      end else begin
        rsp_d = RSP_LS;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_q <= RSP_NONE;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign ls_gnt_o    = ls_gnt;
  assign if_stall_o  = if_req_i & ~if_gnt;
  // a flush landing with the fetch data throws that word away
  assign if_rvalid_o = (rsp_q == RSP_IF) & ~if_flush_i;
  assign ls_rvalid_o = (rsp_q == RSP_LS);
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W], if_addr_i[1:0],
                              ls_addr_i[31:ADDR_W], ls_addr_i[1:0]};

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed and random stimulus for imem_dmem_arbiter against a behavioural model
// with a BRAM fixture attached to the memory port.
module tb_imem_dmem_arbiter;

  localparam int ADDR_W   = 11;
  localparam int MAX_WAIT = 4;
  localparam int WORDS    = 512;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_flush_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_stall_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [8:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;

  int checks = 0;
  int errors = 0;

  imem_dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_stall_o(if_stall_o), .if_rvalid_o(if_rvalid_o),
    .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // BRAM fixture: one-cycle read latency, byte-enabled write
  logic [31:0] bram [WORDS];
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) bram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      mem_rdata_i <= bram[mem_addr_o];
    end
  end

  // reference model state
  logic [31:0] shadow [WORDS];
  int          denied;
  int          pend_owner;   // 0 none, 1 fetch, 2 load
  logic [31:0] pend_data;

  logic        obs_if_gnt, obs_ls_gnt, obs_if_stall, obs_if_rvalid, obs_ls_rvalid;
  logic [31:0] obs_ls_rdata, obs_if_rdata;
  logic [8:0]  obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'(a[ADDR_W-1:2]);
  endfunction

  task automatic model_reset();
    denied     = 0;
    pend_owner = 0;
    pend_data  = '0;
  endtask

  // entered 1ns after a rising edge with inputs already applied
  task automatic cycle();
    logic e_if, e_ls, e_en;
    logic [31:0] e_addr;
    #2;
    e_if = if_req_i && !if_flush_i && (!ls_req_i || denied >= MAX_WAIT);
    e_ls = ls_req_i && !e_if;
    e_en = e_if || e_ls;
    e_addr = e_if ? if_addr_i : ls_addr_i;
    chk("if_gnt", {31'b0, if_gnt_o}, {31'b0, e_if});
    chk("ls_gnt", {31'b0, ls_gnt_o}, {31'b0, e_ls});
    chk("if_stall", {31'b0, if_stall_o}, {31'b0, if_req_i && !e_if});
    chk("mem_en", {31'b0, mem_en_o}, {31'b0, e_en});
    chk("mem_we", {28'b0, mem_we_o}, (e_ls && ls_we_i) ? {28'b0, ls_be_i} : 32'h0);
    if (e_en) chk("mem_addr", {23'b0, mem_addr_o}, 32'(word_of(e_addr)));
    if (e_ls && ls_we_i) chk("mem_wdata", mem_wdata_o, ls_wdata_i);
    chk("if_rvalid", {31'b0, if_rvalid_o}, {31'b0, pend_owner == 1 && !if_flush_i});
    chk("ls_rvalid", {31'b0, ls_rvalid_o}, {31'b0, pend_owner == 2});
    if (pend_owner == 1 && !if_flush_i) chk("if_rdata", if_rdata_o, pend_data);
    if (pend_owner == 2) chk("ls_rdata", ls_rdata_o, pend_data);
    obs_if_gnt = if_gnt_o; obs_ls_gnt = ls_gnt_o; obs_if_stall = if_stall_o;
    obs_if_rvalid = if_rvalid_o; obs_ls_rvalid = ls_rvalid_o;
    obs_ls_rdata = ls_rdata_o; obs_if_rdata = if_rdata_o; obs_addr = mem_addr_o;
    @(posedge clk_i);
    pend_owner = 0;
    if (e_if) begin
      pend_owner = 1;
      pend_data  = shadow[word_of(if_addr_i)];
    end else if (e_ls && !ls_we_i) begin
      pend_owner = 2;
      pend_data  = shadow[word_of(ls_addr_i)];
    end else if (e_ls) begin
      for (int b = 0; b < 4; b++)
        if (ls_be_i[b]) shadow[word_of(ls_addr_i)][8*b +: 8] = ls_wdata_i[8*b +: 8];
    end
    if (!if_req_i || e_if) denied = 0;
    else if (!if_flush_i && denied < MAX_WAIT) denied++;
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_flush_i = 0; ls_req_i = 0; ls_we_i = 0; ls_be_i = 0;
  endtask

  // continuous loads alongside a fetch: fetch must stall exactly MAX_WAIT cycles
  task automatic starve_test(input string tag);
    int stalls = 0;
    logic got = 0;
    for (int i = 0; i < 10; i++) begin
      if_req_i = 1; if_addr_i = 32'h40;
      ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h20 + 32'(4 * i);
      cycle();
      if (obs_if_stall) stalls++;
      if (obs_if_gnt) begin
        got = 1;
        break;
      end
    end
    idle_inputs();
    chk({tag, "_stalls"}, 32'(stalls), 32'(MAX_WAIT));
    chk({tag, "_granted"}, {31'b0, got}, 32'h1);
    cycle();
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      bram[i]   = 32'hA500_0000 ^ (32'(i) * 32'h0101_0107);
      shadow[i] = 32'hA500_0000 ^ (32'(i) * 32'h0101_0107);
    end
    bram[4]   = 32'h1122_3344;
    shadow[4] = 32'h1122_3344;
    model_reset();
    idle_inputs();
    if_addr_i = 0; ls_addr_i = 0; ls_wdata_i = 0;
    rst_i = 1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    cycle();

    // fetch at 0 with idle LSU
    if_req_i = 1; if_addr_i = 32'h0;
    cycle();
    chk("t1_gnt", {31'b0, obs_if_gnt}, 32'h1);
    chk("t1_addr", {23'b0, obs_addr}, 32'h0);
    if_req_i = 0;
    cycle();
    chk("t1_rvalid", {31'b0, obs_if_rvalid}, 32'h1);

    // partial store then load of the same word
    ls_req_i = 1; ls_we_i = 1; ls_be_i = 4'b0011; ls_addr_i = 32'h10; ls_wdata_i = 32'hAABB_CCDD;
    cycle();
    ls_we_i = 0; ls_be_i = 0;
    cycle();
    chk("t2_no_if_rvalid", {31'b0, obs_if_rvalid}, 32'h0);
    chk("t2_no_ls_rvalid", {31'b0, obs_ls_rvalid}, 32'h0);
    ls_req_i = 0;
    cycle();
    chk("t2_ls_rvalid", {31'b0, obs_ls_rvalid}, 32'h1);
    chk("t2_ls_rdata", obs_ls_rdata, 32'h1122_CCDD);

    starve_test("t3");

    // flush arriving with fetch data lets a load through
    if_req_i = 1; if_addr_i = 32'h8;
    cycle();
    if_flush_i = 1; if_addr_i = 32'hC; ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h10;
    cycle();
    chk("t4_if_rvalid", {31'b0, obs_if_rvalid}, 32'h0);
    chk("t4_ls_gnt", {31'b0, obs_ls_gnt}, 32'h1);
    chk("t4_if_gnt", {31'b0, obs_if_gnt}, 32'h0);
    if_flush_i = 0; ls_req_i = 0;
    cycle();
    if_req_i = 0;
    cycle();

    // reset right after a load grant, with the starvation counter part-way up
    for (int i = 0; i < 3; i++) begin
      if_req_i = 1; if_addr_i = 32'h4;
      ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h30;
      cycle();
    end
    idle_inputs();
    rst_i = 1;
    #1;
    chk("t5_ls_rvalid_rst", {31'b0, ls_rvalid_o}, 32'h0);
    chk("t5_if_rvalid_rst", {31'b0, if_rvalid_o}, 32'h0);
    model_reset();
    @(posedge clk_i);
    #1;
    chk("t5_ls_rvalid_hold", {31'b0, ls_rvalid_o}, 32'h0);
    rst_i = 0;
    cycle();
    starve_test("t5");

    // random traffic; requesters hold until granted
    for (int n = 0; n < 600; n++) begin
      if (!if_req_i && $urandom_range(0, 99) < 55) begin
        if_req_i  = 1;
        if_addr_i = ($urandom() & 32'hFFFF_F800) | (32'($urandom_range(0, 15)) << 2)
                    | 32'($urandom_range(0, 3));
      end
      if (!ls_req_i && $urandom_range(0, 99) < 60) begin
        ls_req_i   = 1;
        ls_we_i    = 1'($urandom_range(0, 1));
        ls_be_i    = 4'($urandom_range(0, 15));
        ls_wdata_i = $urandom();
        ls_addr_i  = ($urandom() & 32'hFFFF_F800) | (32'($urandom_range(0, 15)) << 2)
                     | 32'($urandom_range(0, 3));
      end
      if_flush_i = ($urandom_range(0, 99) < 15);
      cycle();
      if (obs_if_gnt) if_req_i = 0;
      if (obs_ls_gnt) ls_req_i = 0;
    end
    idle_inputs();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
